vreg_file_mp: RTL and testbench

Parametrised vector register file, successor to the 4x512-bit single-port register block. It adds:
- NUM_REGS entries of DATA_W bits.
- One direct write port with per-lane write mask.
- Two independent registered read ports.
- A streaming beat loader (valid/ready) that assembles a full register from narrow BEAT_W beats and commits it atomically.

It sits between the memory interface (narrow bus) and the vector datapath (wide operands).

---
 rtl/vreg_file_mp.sv | 119 +++++++++++
 tb/tb_vreg_file_mp.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_file_mp.sv
// Parametrised multi-port vector register file: masked direct write, two
// registered read ports, and a valid/ready beat loader with atomic commit.
module vreg_file_mp #(
  parameter int DATA_W   = 512,
  parameter int NUM_REGS = 4,
  parameter int LANE_W   = 32,
  parameter int BEAT_W   = 64,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int LANES    = DATA_W / LANE_W,
  parameter int BEATS    = DATA_W / BEAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LANES-1:0]  wr_mask,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_abort,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [BEAT_W-1:0] ld_data,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              wr_collision
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMMIT} state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    beat_cnt;
  logic [ADDR_W-1:0]   ld_target;
  logic [DATA_W-1:0]   staging;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic                accept;
  logic                last_beat;

  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    last_beat    = 1'b0;
    ld_ready     = 1'b0;
    ld_busy      = 1'b0;
    ld_done      = 1'b0;
    wr_collision = 1'b0;
    case (state)
      S_IDLE: begin
        if (ld_start) state_nx = S_FILL;
      end
      S_FILL: begin
        ld_ready  = 1'b1;
        ld_busy   = 1'b1;
        // Abort outranks a beat offered in the same cycle.
        accept    = ld_valid && !ld_abort;
        last_beat = accept && (beat_cnt == CNT_W'(BEATS - 1));
        if (ld_abort)       state_nx = S_IDLE;
        else if (last_beat) state_nx = S_COMMIT;
      end
      S_COMMIT: begin
        ld_busy      = 1'b1;
        ld_done      = 1'b1;
        wr_collision = wr_en && (wr_addr == ld_target);
        state_nx     = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      ld_target <= '0;
      staging   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && ld_start) begin
        ld_target <= ld_addr;
        beat_cnt  <= '0;
      end
      if (accept) begin
        staging[beat_cnt*BEAT_W +: BEAT_W] <= ld_data;
        beat_cnt                           <= beat_cnt + 1'b1;
      end
    end
  end

  // Commit owns the whole target register; a colliding direct write is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (wr_en && !wr_collision) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (wr_mask[l]) regs[wr_addr][l*LANE_W +: LANE_W] <= wr_data[l*LANE_W +: LANE_W];
        end
      end
      if (ld_done) regs[ld_target] <= staging;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd0_data <= '0;
      rd1_data <= '0;
    end else begin
      rd0_data <= regs[rd0_addr];
      rd1_data <= regs[rd1_addr];
    end
  end

endmodule

// File: tb/tb_vreg_file_mp.sv
// Scoreboard bench for vreg_file_mp: stimulus queues expected read data,
// a monitor pops and compares when the registered read result appears.
module tb_vreg_file_mp;

  localparam int DW = 512;
  localparam int AW = 2;
  localparam int LN = 16;
  localparam int BW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [LN-1:0] wr_mask = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] rd0_addr = '0;
  logic [DW-1:0] rd0_data;
  logic [AW-1:0] rd1_addr = '0;
  logic [DW-1:0] rd1_data;
  logic          ld_start = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_abort = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [BW-1:0] ld_data = '0;
  logic          ld_busy;
  logic          ld_done;
  logic          wr_collision;

  vreg_file_mp #(.DATA_W(512), .NUM_REGS(4), .LANE_W(32), .BEAT_W(64)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .rd0_addr(rd0_addr), .rd0_data(rd0_data),
    .rd1_addr(rd1_addr), .rd1_data(rd1_data),
    .ld_start(ld_start), .ld_addr(ld_addr), .ld_abort(ld_abort),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_busy(ld_busy), .ld_done(ld_done), .wr_collision(wr_collision)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int coll_cnt = 0;

  string         nq[$];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          rd_req = 1'b0;
  logic          rd_pend = 1'b0;

  function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] lanes_fill(logic [31:0] base);
    logic [DW-1:0] r;
    for (int i = 0; i < LN; i++) r[i*32 +: 32] = base + 32'(i);
    return r;
  endfunction

  function automatic logic [DW-1:0] beats_fill(logic [63:0] mult, logic [63:0] add);
    logic [DW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*64 +: 64] = add + mult * 64'(k);
    return r;
  endfunction

  // Monitor: counts loader/collision pulses and scores read results.
  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    if (ld_done === 1'b1) done_cnt++;
    if (wr_collision === 1'b1) coll_cnt++;
    if (rd_pend) begin
      if (nq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_queue: got a read result, expected no pending read");
      end else begin
        string n;
        logic [DW-1:0] e0, e1;
        n  = nq.pop_front();
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        check({n, "/rd0"}, rd0_data, e0);
        check({n, "/rd1"}, rd1_data, e1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic issue_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                            input string name);
    rd0_addr = a0;
    rd1_addr = a1;
    rd_req   = 1'b1;
    nq.push_back(name);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic send_beat(input logic [BW-1:0] d);
    ld_valid = 1'b1;
    ld_data  = d;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic start_load(input logic [AW-1:0] a);
    ld_start = 1'b1;
    ld_addr  = a;
    step();
    ld_start = 1'b0;
  endtask

  logic [DW-1:0] pA, p2, p3, p0, p5, p5b, pW, p6, ones;

  initial begin
    pA   = lanes_fill(32'hA5A5_0000);
    ones = '1;
    p2   = '0;
    p2[31:0]  = 32'hFFFF_FFFF;
    p2[95:64] = 32'hFFFF_FFFF;
    p3   = beats_fill(64'h1111, 64'h0);
    p0   = {16{32'h600D_F00D}};
    p5   = beats_fill(64'h1, 64'hF0F0_0000_0000_0000);
    p5b  = beats_fill(64'h1, 64'h0123_4567_0000_0000);
    pW   = {16{32'h5555_5555}};
    p6   = beats_fill(64'h10, 64'hABCD_0000_0000_0000);

    // Reset state on all addresses.
    #2;
    check_int("rst_ld_ready", int'(ld_ready), 0);
    check_int("rst_ld_busy", int'(ld_busy), 0);
    check_int("rst_ld_done", int'(ld_done), 0);
    check_int("rst_wr_collision", int'(wr_collision), 0);
    for (int a = 0; a < 4; a++) begin
      rd0_addr = AW'(a);
      rd1_addr = AW'(3 - a);
      step();
      check("rst_rd0", rd0_data, '0);
      check("rst_rd1", rd1_data, '0);
    end
    reset = 1'b1;
    step();

    // Test 1: full write of reg2; a read issued in the write cycle sees old data.
    wr_en = 1'b1; wr_addr = 2; wr_mask = 16'hFFFF; wr_data = pA;
    issue_read(2, 2, '0, '0, "t1_read_old");
    step();
    wr_en = 1'b0;
    issue_read(2, 2, pA, pA, "t1_reg2");
    step();

    // Test 2: lane mask, then an empty mask.
    wr_en = 1'b1; wr_addr = 1; wr_mask = 16'h0005; wr_data = ones;
    step();
    wr_mask = '0; wr_data = '0;
    issue_read(1, 1, p2, p2, "t2_mask5");
    step();
    wr_en = 1'b0;
    issue_read(1, 0, p2, '0, "t2_mask0");
    step();

    // Test 3: toggled-valid load into reg3, with an ignored ld_start mid-FILL.
    start_load(3);
    check_int("t3_busy_fill", int'(ld_busy), 1);
    check_int("t3_ready_fill", int'(ld_ready), 1);
    for (int k = 0; k < 8; k++) begin
      ld_valid = 1'b0;
      if (k == 2) begin ld_start = 1'b1; ld_addr = 1; end
      step();
      ld_start = 1'b0;
      send_beat(64'h1111 * 64'(k));
    end
    check_int("t3_done_commit", int'(ld_done), 1);
    check_int("t3_ready_commit", int'(ld_ready), 0);
    check_int("t3_busy_commit", int'(ld_busy), 1);
    step();
    check_int("t3_busy_after", int'(ld_busy), 0);
    check_int("t3_done_after", int'(ld_done), 0);
    check_int("t3_done_count", done_cnt, 1);
    issue_read(3, 1, p3, p2, "t3_reg3_reg1");
    step();

    // Test 4: abort after three beats, with a beat offered in the abort cycle.
    wr_en = 1'b1; wr_addr = 0; wr_mask = 16'hFFFF; wr_data = p0;
    step();
    wr_en = 1'b0;
    start_load(0);
    for (int k = 0; k < 3; k++) send_beat(64'hBAD0 + 64'(k));
    ld_valid = 1'b1; ld_data = 64'hDEAD; ld_abort = 1'b1;
    step();
    ld_valid = 1'b0; ld_abort = 1'b0;
    check_int("t4_busy_abort", int'(ld_busy), 0);
    check_int("t4_ready_abort", int'(ld_ready), 0);
    step();
    check_int("t4_done_count", done_cnt, 1);
    issue_read(0, 0, p0, p0, "t4_reg0_kept");
    step();

    // Test 5a: direct write to the commit target in the COMMIT cycle.
    start_load(3);
    for (int k = 0; k < 8; k++) send_beat(64'hF0F0_0000_0000_0000 + 64'(k));
    wr_en = 1'b1; wr_addr = 3; wr_mask = 16'hFFFF; wr_data = pW;
    #1;
    check_int("t5_collision", int'(wr_collision), 1);
    step();
    wr_en = 1'b0;
    check_int("t5_coll_count", coll_cnt, 1);
    issue_read(3, 3, p5, p5, "t5_reg3_commit_wins");
    step();

    // Test 5b: direct write to a different register in the COMMIT cycle.
    start_load(3);
    for (int k = 0; k < 8; k++) send_beat(64'h0123_4567_0000_0000 + 64'(k));
    wr_en = 1'b1; wr_addr = 1; wr_mask = 16'hFFFF; wr_data = pW;
    #1;
    check_int("t5b_no_collision", int'(wr_collision), 0);
    step();
    wr_en = 1'b0;
    issue_read(3, 1, p5b, pW, "t5b_both_land");
    step();
    check_int("t5b_coll_count", coll_cnt, 1);
    check_int("t5b_done_count", done_cnt, 3);

    // Test 6: reset mid-FILL, then a fresh load.
    start_load(2);
    for (int k = 0; k < 5; k++) send_beat(64'h7777_0000 + 64'(k));
    reset = 1'b0;
    #1;
    check_int("t6_busy_reset", int'(ld_busy), 0);
    check_int("t6_ready_reset", int'(ld_ready), 0);
    check("t6_rd0_reset", rd0_data, '0);
    check("t6_rd1_reset", rd1_data, '0);
    step();
    reset = 1'b1;
    step();
    for (int a = 0; a < 4; a++) begin
      issue_read(AW'(a), AW'(3 - a), '0, '0, "t6_cleared");
      step();
    end
    start_load(1);
    for (int k = 0; k < 8; k++) send_beat(64'hABCD_0000_0000_0000 + 64'h10 * 64'(k));
    step();
    issue_read(1, 2, p6, '0, "t6_fresh_load");
    step();
    check_int("t6_done_count", done_cnt, 4);

    step();
    step();
    check_int("pending_reads", nq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
